tick_gen: RTL and testbench
===========================

# tick_gen

Parametrised, runtime-programmable enable-pulse generator. Produces a one-cycle `tick` every DIV+1 clocks, a second-stage `tick_post` every POST+1 ticks, and a 50%-per-tick square wave `sq`. Divisors load through a shadow register and take effect only at a period boundary, so rates change without glitches. Sits beside the game logic as the single source of slow-rate enables (display refresh, game step, blink), replacing fixed hard-coded dividers.

## Interface
- `WIDTH`, 25: prescaler counter/divisor width
- `RESET_DIV`, 25000000: prescaler divisor after reset (period = RESET_DIV+1 clocks); must fit in WIDTH
- `POST_WIDTH`, 8: post-scaler width
- `RESET_POST`, 3: post-scaler divisor after reset (tick_post period = RESET_POST+1 ticks)

- `clk` in 1: system clock; all state on rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset)
- `en` in 1: count enable; 0 freezes counters
- `div_in` in WIDTH: new prescaler divisor
- `post_in` in POST_WIDTH: new post-scaler divisor
- `load` in 1: one-cycle strobe capturing div_in/post_in
- `load_pending` out 1: shadow values captured, not yet applied
- `tick` out 1: one-cycle pulse per prescaler period
- `tick_post` out 1: one-cycle pulse per POST+1 ticks, coincident with a tick
- `sq` out 1: toggles on every tick
- `count` out WIDTH: current prescaler count (debug)

## Operation
- Reset (rst=0, async): count=0, post_cnt=0, div_act=RESET_DIV, post_act=RESET_POST, shadow=reset values, tick=0, tick_post=0, sq=0, load_pending=0.
- en=1, count≠div_act: count<=count+1; tick<=0; tick_post<=0.
- en=1, count==div_act (wrap): count<=0; tick<=1; sq<=~sq; if post_cnt==post_act then post_cnt<=0, tick_post<=1, else post_cnt<=post_cnt+1, tick_post<=0.
- en=0: count, post_cnt, sq hold; tick and tick_post registered 0.
- load with en=1: shadow<=div_in/post_in; load_pending<=1. A second load before apply overwrites shadow (last wins).
- Apply: at the first wrap after the load cycle with load_pending=1: div_act<=shadow_div, post_act<=shadow_post, post_cnt<=0, load_pending<=0, tick_post<=0 for that wrap. The wrap tick itself ends the old-rate period.
- load coincident with wrap: shadow captured, applied at the *next* wrap, not this one.
- load with en=0: applied on that edge: div_act/post_act updated, count<=0, post_cnt<=0, load_pending stays 0; sq holds.
- div_act=0: wrap every enabled cycle; tick stays 1 continuously while en=1; sq toggles every cycle.
- post_act=0: tick_post identical to tick.
- Divisor below current count cannot occur (apply only at wrap, count=0).

## Timing
- All outputs registered; no combinational input-to-output paths.
- After reset release with en=1 held: first tick high in the cycle following the (div_act+1)th rising edge; thereafter period exactly div_act+1 clocks, high 1 clock (div_act>0).
- tick_post first asserts with the (post_act+1)th tick after reset/apply.
- load_pending rises the cycle after load; falls the cycle after the applying wrap edge.
- New rate: the period beginning at the applying wrap uses new div_act.
- en deassert mid-period: remaining count resumes on re-enable; no cycles lost or added beyond en-low time.
- Async reset mid-period: all outputs 0 immediately, independent of clk.

## Test plan
(WIDTH=8, RESET_DIV=4, POST_WIDTH=4, RESET_POST=2)
- Reset, en=1 for 40 cycles -> tick one-cycle pulses every 5 clocks, first after 5th edge; tick_post on every 3rd tick (every 15 clocks); sq toggles at each tick.
- load div_in=2, post_in=0 at count=1 -> load_pending=1; next tick still 5 clocks after previous; subsequent ticks every 3 clocks, tick_post==tick; load_pending clears after that wrap.
- Two loads (div_in=7 then 1) before wrap; load coincident with wrap (div_in=3) -> divisor 1 applied; 3 applied only at following wrap.
- div_in=0 applied -> tick constant 1 with en=1, sq toggles every clock; en=0 -> tick 0, sq holds.
- en low for 10 cycles at count=2 -> no ticks, count stays 2; tick 3 clocks after en returns (count 2->3->4->wrap).
- rst pulsed low between edges at count=3 after div change to 6 -> outputs 0 immediately; after release div_act=4 (ticks every 5); load with en=0, div_in=1 -> count=0 next edge, ticks every 2 once en=1.

Source files
------------

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - programmable prescaler/post-scaler tick generator with shadowed divisors
module tick_gen #(
    parameter int WIDTH      = 25,
    parameter int RESET_DIV  = 25000000,
    parameter int POST_WIDTH = 8,
    parameter int RESET_POST = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WIDTH-1:0]      div_in,
    input  logic [POST_WIDTH-1:0] post_in,
    input  logic                  load,
    output logic                  load_pending,
    output logic                  tick,
    output logic                  tick_post,
    output logic                  sq,
    output logic [WIDTH-1:0]      count
);

    localparam logic [WIDTH-1:0]      RST_DIV  = WIDTH'(RESET_DIV);
    localparam logic [POST_WIDTH-1:0] RST_POST = POST_WIDTH'(RESET_POST);
    localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
    localparam logic [POST_WIDTH-1:0] POST_ONE = POST_WIDTH'(1);

    logic [WIDTH-1:0]      count_q, count_d;
    logic [POST_WIDTH-1:0] post_cnt_q, post_cnt_d;
    logic [WIDTH-1:0]      div_act_q, div_act_d;
    logic [POST_WIDTH-1:0] post_act_q, post_act_d;
    logic [WIDTH-1:0]      shadow_div_q, shadow_div_d;
    logic [POST_WIDTH-1:0] shadow_post_q, shadow_post_d;
    logic                  load_pending_q, load_pending_d;
    logic                  tick_q, tick_d;
    logic                  tick_post_q, tick_post_d;
    logic                  sq_q, sq_d;

    always_comb begin
        count_d        = count_q;
        post_cnt_d     = post_cnt_q;
        div_act_d      = div_act_q;
        post_act_d     = post_act_q;
        shadow_div_d   = shadow_div_q;
        shadow_post_d  = shadow_post_q;
        load_pending_d = load_pending_q;
        tick_d         = 1'b0;
        tick_post_d    = 1'b0;
        sq_d           = sq_q;

        if (!en) begin
            // While frozen there is no period boundary to wait for, so a load applies at once.
            if (load) begin
                div_act_d      = div_in;
                post_act_d     = post_in;
                shadow_div_d   = div_in;
                shadow_post_d  = post_in;
                count_d        = '0;
                post_cnt_d     = '0;
                load_pending_d = 1'b0;
            end
        end else begin
            if (count_q == div_act_q) begin
                count_d = '0;
                tick_d  = 1'b1;
                sq_d    = ~sq_q;
                if (load_pending_q) begin
                    div_act_d      = shadow_div_q;
                    post_act_d     = shadow_post_q;
                    post_cnt_d     = '0;
                    load_pending_d = 1'b0;
                end else if (post_cnt_q == post_act_q) begin
                    post_cnt_d  = '0;
                    tick_post_d = 1'b1;
                end else begin
                    post_cnt_d = post_cnt_q + POST_ONE;
                end
            end else begin
                count_d = count_q + CNT_ONE;
            end

            // A load on the wrap edge itself re-arms pending, deferring it to the next wrap.
            if (load) begin
                shadow_div_d   = div_in;
                shadow_post_d  = post_in;
                load_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q        <= '0;
            post_cnt_q     <= '0;
            div_act_q      <= RST_DIV;
            post_act_q     <= RST_POST;
            shadow_div_q   <= RST_DIV;
            shadow_post_q  <= RST_POST;
            load_pending_q <= 1'b0;
            tick_q         <= 1'b0;
            tick_post_q    <= 1'b0;
            sq_q           <= 1'b0;
        end else begin
            count_q        <= count_d;
            post_cnt_q     <= post_cnt_d;
            div_act_q      <= div_act_d;
            post_act_q     <= post_act_d;
            shadow_div_q   <= shadow_div_d;
            shadow_post_q  <= shadow_post_d;
            load_pending_q <= load_pending_d;
            tick_q         <= tick_d;
            tick_post_q    <= tick_post_d;
            sq_q           <= sq_d;
        end
    end

    assign load_pending = load_pending_q;
    assign tick         = tick_q;
    assign tick_post    = tick_post_q;
    assign sq           = sq_q;
    assign count        = count_q;

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - scoreboard bench for tick_gen against a period-level reference model
module tb_tick_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] div_in = '0;
    logic [3:0] post_in = '0;
    logic       load = 1'b0;
    logic       load_pending, tick, tick_post, sq;
    logic [7:0] count;

    int checks = 0;
    int failures = 0;

    tick_gen #(.WIDTH(8), .RESET_DIV(4), .POST_WIDTH(4), .RESET_POST(2)) dut (
        .clk(clk), .rst(rst), .en(en), .div_in(div_in), .post_in(post_in),
        .load(load), .load_pending(load_pending), .tick(tick),
        .tick_post(tick_post), .sq(sq), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       tick_post;
        logic       sq;
        logic       lp;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: position inside the current period and ticks since the last rate change.
    int m_elapsed, m_period, m_post_period, m_next_period, m_next_post_period;
    int m_ticks;
    bit m_pend, m_sq, m_tick, m_tp;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_elapsed = 0; m_period = 5; m_post_period = 3;
        m_next_period = 5; m_next_post_period = 3;
        m_ticks = 0; m_pend = 0; m_sq = 0; m_tick = 0; m_tp = 0;
    endtask

    task automatic model_step(input bit e, input bit l, input int d, input int p);
        m_tick = 0;
        m_tp = 0;
        if (!e) begin
            if (l) begin
                m_period = d + 1; m_post_period = p + 1;
                m_next_period = d + 1; m_next_post_period = p + 1;
                m_elapsed = 0; m_ticks = 0; m_pend = 0;
            end
        end else begin
            if (m_elapsed + 1 == m_period) begin
                m_elapsed = 0;
                m_tick = 1;
                m_sq = !m_sq;
                if (m_pend) begin
                    m_period = m_next_period;
                    m_post_period = m_next_post_period;
                    m_ticks = 0;
                    m_pend = 0;
                end else begin
                    m_ticks++;
                    m_tp = (m_ticks % m_post_period) == 0;
                end
            end else begin
                m_elapsed++;
            end
            if (l) begin
                m_next_period = d + 1;
                m_next_post_period = p + 1;
                m_pend = 1;
            end
        end
    endtask

    task automatic step(input bit e, input bit l, input int d, input int p);
        exp_t x;
        en = e; load = l; div_in = 8'(d); post_in = 4'(p);
        model_step(e, l, d, p);
        @(posedge clk);
        #1;
        x.tick = m_tick; x.tick_post = m_tp; x.sq = m_sq; x.lp = m_pend;
        x.cnt = 8'(m_elapsed);
        exp_q.push_back(x);
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(e, 0, 0, 0);
    endtask

    task automatic wait_count(input int c);
        int guard = 0;
        while (m_elapsed != c && guard < 50) begin
            step(1, 0, 0, 0);
            guard++;
        end
        chk("wait_count_reached", m_elapsed, c);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tick"}, int'(tick), 0);
        chk({tag, "_tick_post"}, int'(tick_post), 0);
        chk({tag, "_sq"}, int'(sq), 0);
        chk({tag, "_load_pending"}, int'(load_pending), 0);
        chk({tag, "_count"}, int'(count), 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tick", int'(tick), int'(e.tick));
            chk("tick_post", int'(tick_post), int'(e.tick_post));
            chk("sq", int'(sq), int'(e.sq));
            chk("load_pending", int'(load_pending), int'(e.lp));
            chk("count", int'(count), int'(e.cnt));
        end
    end

    initial begin
        model_reset();
        #1;
        check_zero("reset");
        @(negedge clk);
        #1;
        rst = 1'b1;

        run(40, 1);

        wait_count(1);
        step(1, 1, 2, 0);
        run(20, 1);

        // Two loads before the wrap, then one landing on the wrap edge itself.
        wait_count(0);
        step(1, 1, 7, 3);
        step(1, 1, 1, 1);
        step(1, 1, 3, 1);
        run(15, 1);

        step(1, 1, 0, 0);
        run(15, 1);
        run(5, 0);
        run(5, 1);

        step(1, 1, 4, 1);
        run(12, 1);
        wait_count(2);
        run(10, 0);
        run(8, 1);

        step(0, 1, 6, 2);
        wait_count(3);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        rst = 1'b1;
        model_reset();
        run(12, 1);
        step(0, 1, 1, 0);
        run(8, 1);

        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, ($urandom % 10) == 0, $urandom % 6, $urandom % 4);
        end

        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
